// File: rtl/fmult_share_arb_pkg.sv
// fmult_share_arb_pkg: shared sizing defaults and occupancy states for the f_mult arbiter
package fmult_share_arb_pkg;
  localparam int FLEN = 64;
  localparam int NREQ_DEF = 3;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {EMPTY, RUN, FULL} occ_t;
endpackage

// File: rtl/fmult_share_arb_if.sv
// fmult_share_arb_if: requester and multiplier signals of the shared f_mult arbiter
interface fmult_share_arb_if
  import fmult_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  logic [NREQ-1:0] req_vld;
  logic [NREQ-1:0][FLEN-1:0] req_a;
  logic [NREQ-1:0][FLEN-1:0] req_b;
  logic [NREQ-1:0] req_gnt;
  logic [NREQ-1:0] rsp_vld;
  logic [FLEN-1:0] rsp_res;
  logic rsp_err;
  logic [FLEN-1:0] m_a;
  logic [FLEN-1:0] m_b;
  logic m_up_valid;
  logic [FLEN-1:0] m_res;
  logic m_down_valid;
  logic m_busy;
  logic m_error;
  modport master (
    output req_vld, req_a, req_b, m_res, m_down_valid, m_busy, m_error,
    input req_gnt, rsp_vld, rsp_res, rsp_err, m_a, m_b, m_up_valid
  );
  modport slave (
    input req_vld, req_a, req_b, m_res, m_down_valid, m_busy, m_error,
    output req_gnt, rsp_vld, rsp_res, rsp_err, m_a, m_b, m_up_valid
  );
endinterface

// File: rtl/fmult_share_arb_tag_fifo.sv
// tag_fifo: in-order requester tags for in-flight multiplications, same-cycle push/pop
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fmult_share_arb.sv
// fmult_share_arb: round-robin sharing of one in-order f_mult among NREQ requesters,
// routing each result back to its issuer through a tag FIFO with zero added latency
module fmult_share_arb
  import fmult_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  fmult_share_arb_if.slave bus,
  output logic busy,
  output logic proto_err
);
  localparam int W = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [W-1:0] rr, win, head;
  logic any, issue, pop;
  logic [CW-1:0] count;
  occ_t state, state_n;
  // iterate farthest-first so the nearest requester after rr overwrites the winner
  always_comb begin
    win = rr;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req_vld[W'((int'(rr) + k) % NREQ)]) begin
        win = W'((int'(rr) + k) % NREQ);
        any = 1'b1;
      end
  end
  assign pop = bus.m_down_valid & ~rst & (state != EMPTY);
  assign issue = any & ~bus.m_busy & ~rst & ((state != FULL) | pop);
  assign bus.req_gnt = issue ? (NREQ'(1) << win) : '0;
  assign bus.m_up_valid = issue;
  assign bus.m_a = bus.req_a[win];
  assign bus.m_b = bus.req_b[win];
  assign bus.rsp_vld = pop ? (NREQ'(1) << head) : '0;
  assign bus.rsp_res = bus.m_res;
  assign bus.rsp_err = pop & bus.m_error;
  assign busy = ~rst & (state != EMPTY);
  always_comb begin
    state_n = state;
    if (issue & ~pop) state_n = (count == CW'(DEPTH - 1)) ? FULL : RUN;
    else if (pop & ~issue) state_n = (count == CW'(1)) ? EMPTY : RUN;
  end
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      rr <= '0;
      proto_err <= 1'b0;
    end else begin
      if (issue) rr <= (win == W'(NREQ - 1)) ? '0 : win + 1'b1;
      if (bus.m_down_valid & (state == EMPTY)) proto_err <= 1'b1;
    end
  tag_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(issue),
    .pop(pop),
    .din(win),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_fmult_share_arb.sv
// tb_fmult_share_arb: randomized and directed scoreboard bench with a latency-configurable f_mult model
module tb_fmult_share_arb;
  import fmult_share_arb_pkg::*;
  localparam int NREQ = 3;
  localparam int DEPTH = 4;
  typedef struct {int t; logic [63:0] r; logic e;} exp_t;
  typedef struct {logic [63:0] r; logic e; int due;} mod_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, proto_err;
  fmult_share_arb_if #(.NREQ(NREQ)) bus ();
  fmult_share_arb dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .proto_err(proto_err));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int cyc = 0, lat = 3, rr_ref = 0;
  bit pe_ref = 0, rst_cmd = 1, keep = 0, rand_on = 0, mbusy_rand = 0, mbusy_force = 0, force_dv = 0;
  logic [NREQ-1:0] rv = '0, ld_vld = '0, gnt_prev = '0;
  logic [63:0] ra [NREQ], rb [NREQ], ld_a [NREQ], ld_b [NREQ];
  exp_t sb [$];
  mod_t mq [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction
  function automatic logic ferr(input logic [63:0] a, input logic [63:0] b);
    return (a[62:52] == 11'h7ff) || (b[62:52] == 11'h7ff);
  endfunction
  function automatic logic [63:0] rnd_op();
    if ($urandom_range(0, 15) == 0) return 64'h7ff0000000000000;
    return $realtobits(real'($urandom_range(1, 4000)) / 16.0);
  endfunction
  task automatic load(input int i, input logic [63:0] a, input logic [63:0] b);
    ld_a[i] = a;
    ld_b[i] = b;
    ld_vld[i] = 1'b1;
  endtask
  // requesters and the f_mult model change inputs just after the rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    rst = rst_cmd;
    bus.m_busy = mbusy_force || (mbusy_rand && $urandom_range(0, 3) == 0);
    for (int i = 0; i < NREQ; i++)
      if (ld_vld[i]) begin
        rv[i] = 1'b1; ra[i] = ld_a[i]; rb[i] = ld_b[i]; ld_vld[i] = 1'b0;
      end else if (gnt_prev[i]) begin
        if (keep) begin ra[i] = rnd_op(); rb[i] = rnd_op(); end
        else rv[i] = 1'b0;
      end else if (!rv[i] && rand_on && $urandom_range(0, 3) == 0) begin
        rv[i] = 1'b1; ra[i] = rnd_op(); rb[i] = rnd_op();
      end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i] = ra[i];
      bus.req_b[i] = rb[i];
    end
    bus.req_vld = rv;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      bus.m_down_valid = 1'b1; bus.m_res = mq[0].r; bus.m_error = mq[0].e;
      void'(mq.pop_front());
    end else begin
      bus.m_down_valid = force_dv; bus.m_res = {$urandom, $urandom}; bus.m_error = 1'b0;
    end
    force_dv = 0;
  end
  // scoreboard monitor: expected grant from rr order, expected response from issue order
  always @(negedge clk) begin
    int w;
    bit iss, pp;
    exp_t e;
    if (rst) begin
      chk("rst_gnt", 64'(bus.req_gnt), 0);
      chk("rst_rsp_vld", 64'(bus.rsp_vld), 0);
      chk("rst_busy", 64'(busy), 0);
      sb.delete(); mq.delete(); rr_ref = 0; pe_ref = 0; gnt_prev = '0;
    end else begin
      chk("busy", 64'(busy), 64'(sb.size() != 0));
      chk("proto_err", 64'(proto_err), 64'(pe_ref));
      pp = bus.m_down_valid && sb.size() != 0;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.req_vld[(rr_ref + k) % NREQ]) w = (rr_ref + k) % NREQ;
      iss = w >= 0 && !bus.m_busy && (sb.size() < DEPTH || pp);
      chk("gnt", 64'(bus.req_gnt), iss ? 64'(1) << w : 64'(0));
      chk("m_up_valid", 64'(bus.m_up_valid), 64'(iss));
      if (iss) begin
        chk("m_a", bus.m_a, ra[w]);
        chk("m_b", bus.m_b, rb[w]);
      end
      if (pp) begin
        e = sb.pop_front();
        chk("rsp_vld", 64'(bus.rsp_vld), 64'(1) << e.t);
        chk("rsp_res", bus.rsp_res, e.r);
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.e));
      end else begin
        chk("rsp_idle", 64'(bus.rsp_vld), 0);
        if (bus.m_down_valid) pe_ref = 1;
      end
      if (iss) begin
        sb.push_back('{w, fmul(ra[w], rb[w]), ferr(ra[w], rb[w])});
        rr_ref = (w + 1) % NREQ;
      end
      if (bus.m_up_valid) mq.push_back('{fmul(bus.m_a, bus.m_b), ferr(bus.m_a, bus.m_b), cyc + lat});
      gnt_prev = bus.req_gnt;
    end
  end
  task automatic wait_idle();
    int n;
    for (n = 0; n < 400 && !(rv == '0 && ld_vld == '0 && sb.size() == 0 && mq.size() == 0); n++)
      @(negedge clk);
    chk("idle_timeout", 64'(n >= 400), 0);
  endtask
  task automatic wait_count(input int c);
    int n;
    for (n = 0; n < 40 && dut.count != 3'(c); n++) @(negedge clk);
    chk("count_timeout", 64'(n >= 40), 0);
  endtask
  initial begin
    int n;
    bus.req_vld = '0; bus.m_busy = 0; bus.m_down_valid = 0; bus.m_error = 0; bus.m_res = '0;
    bus.req_a = '0; bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    repeat (3) @(negedge clk);
    rst_cmd = 0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_count", 64'(dut.count), 0);
    chk("reset_proto", 64'(proto_err), 0);
    lat = 3;
    load(1, 64'h4000000000000000, 64'h4008000000000000);
    wait_idle();
    rst_cmd = 1; keep = 1; lat = 2;
    for (int i = 0; i < NREQ; i++) load(i, rnd_op(), rnd_op());
    @(negedge clk);
    rst_cmd = 0;
    repeat (20) @(negedge clk);
    keep = 0;
    wait_idle();
    lat = 8; keep = 1;
    for (int i = 0; i < NREQ; i++) load(i, rnd_op(), rnd_op());
    wait_count(4);
    repeat (2) @(negedge clk);
    chk("bp_full_state", 64'(dut.state), 64'(FULL));
    chk("bp_full_gnt", 64'(bus.req_gnt), 0);
    for (n = 0; n < 20 && !bus.m_down_valid; n++) @(negedge clk);
    chk("bp_pop_gnt", 64'(bus.req_gnt != '0), 1);
    @(negedge clk);
    chk("bp_count", 64'(dut.count), 4);
    keep = 0;
    wait_idle();
    lat = 4;
    load(2, 64'h7ff0000000000000, 64'h3ff8000000000000);
    wait_idle();
    force_dv = 1;
    repeat (2) @(negedge clk);
    chk("proto_set", 64'(proto_err), 1);
    lat = 8;
    load(0, rnd_op(), rnd_op());
    load(1, rnd_op(), rnd_op());
    wait_count(2);
    rst_cmd = 1;
    @(negedge clk);
    rst_cmd = 0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_count", 64'(dut.count), 0);
    repeat (12) @(negedge clk);
    mbusy_force = 1; lat = 2;
    load(0, rnd_op(), rnd_op());
    repeat (5) begin
      @(negedge clk);
      chk("mbusy_hold_gnt", 64'(bus.req_gnt), 0);
    end
    mbusy_force = 0;
    @(negedge clk);
    chk("mbusy_release_gnt", 64'(bus.req_gnt), 1);
    wait_idle();
    repeat (5) begin
      lat = $urandom_range(1, 6);
      rand_on = 1; mbusy_rand = 1;
      repeat (80) @(negedge clk);
      rand_on = 0; mbusy_rand = 0;
      wait_idle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
